// File: rtl/mode2_rate_meter_pkg.sv
// mode2_pkg: shared types and defaults for the Mode 2 rate meter.
package mode2_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/mode2_rate_meter_if.sv
// Result/handshake bundle between the rate meter and its driver/consumer.
// slave: the meter side. master: the stimulus/consumer side.
interface mode2_rate_meter_if #(parameter int CNT_W = 8) ();
  logic             gate;
  logic             sig;
  logic             ack;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] low_time;
  logic             valid;
  logic             overrun;
  logic             timeout;

  modport slave (
    input  gate, sig, ack,
    output period, low_time, valid, overrun, timeout
  );

  modport master (
    output gate, sig, ack,
    input  period, low_time, valid, overrun, timeout
  );
endinterface

// File: rtl/mode2_rate_meter_edge_sync.sv
// mode2_edge_sync: samples sig into s_q, keeps the previous sample in s_qq
// and flags a rising edge. Defining MODE2_METER_SYNC_EN adds a two-flop
// synchronizer ahead of s_q so sig may be asynchronous to clk.
module mode2_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic s_q,
  output logic rise
);

  logic s_qq;
  logic sig_in;

`ifdef MODE2_METER_SYNC_EN
  logic [1:0] sync_q;

  // Two-flop synchronizer; adds two cycles of latency, values unchanged.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], sig};
  end

  assign sig_in = sync_q[1];
`else
  assign sig_in = sig;
`endif

  // Sample register and its one-cycle-delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q  <= 1'b0;
      s_qq <= 1'b0;
    end else begin
      s_q  <= sig_in;
      s_qq <= s_q;
    end
  end

  assign rise = s_q & ~s_qq;

endmodule

// File: rtl/mode2_rate_meter.sv
// mode2_rate_meter: measures clk cycles between rising edges of sig and the
// low samples within each period; results are held on a valid/ack handshake
// with a sticky overrun flag and a one-cycle timeout pulse.
// Optional build macro: MODE2_METER_SYNC_EN (synchronizer on sig).
module mode2_rate_meter
  import mode2_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  mode2_rate_meter_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] lcnt;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] low_q;
  logic             valid_q;
  logic             overrun_q;
  logic             timeout_q;
  logic             s_q;
  logic             rise;

  mode2_edge_sync u_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (bus.sig),
    .s_q  (s_q),
    .rise (rise)
  );

  // Measurement FSM, counters and result handshake with registered outputs.
  // The ack clear is applied first so a same-cycle publish overrides it:
  // ack consumes the old result and the new one stays valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      lcnt      <= '0;
      period_q  <= '0;
      low_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (bus.ack && valid_q) begin
        valid_q   <= 1'b0;
        overrun_q <= 1'b0;
      end
      if (!bus.gate) begin
        // Gate low aborts the period in progress; held results survive.
        state <= IDLE;
        cnt   <= '0;
        lcnt  <= '0;
      end else begin
        case (state)
          IDLE: state <= ARM;
          ARM: begin
            if (rise) begin
              cnt   <= CNT_ONE;
              lcnt  <= '0;
              state <= MEASURE;
            end
          end
          MEASURE: begin
            if (rise) begin
              period_q  <= cnt;
              low_q     <= lcnt;
              valid_q   <= 1'b1;
              // Unacked pending result gets overwritten -> overrun.
              overrun_q <= valid_q ? ~bus.ack : overrun_q;
              cnt       <= CNT_ONE;
              lcnt      <= '0;
            end else if (cnt == CNT_MAX) begin
              // No edge within the longest measurable period.
              timeout_q <= 1'b1;
              state     <= ARM;
              cnt       <= '0;
              lcnt      <= '0;
            end else begin
              cnt  <= cnt + CNT_ONE;
              lcnt <= lcnt + {{(CNT_W-1){1'b0}}, ~s_q};
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.period   = period_q;
  assign bus.low_time = low_q;
  assign bus.valid    = valid_q;
  assign bus.overrun  = overrun_q;
  assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_mode2_rate_meter.sv
// Directed bench for mode2_rate_meter: a per-cycle vector table on an
// 8-bit instance, plus hand sequences on a 4-bit instance for timeout and
// the full-scale period.
module tb_mode2_rate_meter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mode2_rate_meter_if #(.CNT_W(8)) m_if ();
  mode2_rate_meter_if #(.CNT_W(4)) t_if ();

  mode2_rate_meter #(.CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (m_if.slave)
  );

  mode2_rate_meter #(.CNT_W(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (t_if.slave)
  );

  typedef struct {
    logic       rst;
    logic       gate;
    logic       sig;
    logic       ack;
    logic [7:0] period;
    logic [7:0] low_time;
    logic       valid;
    logic       overrun;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic r, g, s, a, input logic [7:0] p, l,
                     input logic v, o);
    vec_t e;
    e.rst = r; e.gate = g; e.sig = s; e.ack = a;
    e.period = p; e.low_time = l; e.valid = v; e.overrun = o;
    tv.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int to_cnt;
  int to_at;
  int v_seen;

  initial begin
    m_if.gate = 1'b0; m_if.sig = 1'b0; m_if.ack = 1'b0;
    t_if.gate = 1'b0; t_if.sig = 1'b0; t_if.ack = 1'b0;

    //  rst g s a   period low v o
    add(1, 0, 0, 0, 0, 0, 0, 0);  // reset state
    // N=3 source (high 2, low 1), acking each result
    add(0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 3, 1, 1, 0);
    add(0, 1, 0, 1, 3, 1, 0, 0);
    add(0, 1, 1, 0, 3, 1, 0, 0);
    add(0, 1, 1, 0, 3, 1, 1, 0);
    add(0, 1, 0, 1, 3, 1, 0, 0);
    add(0, 1, 1, 0, 3, 1, 0, 0);
    add(0, 1, 1, 0, 3, 1, 1, 0);
    // withhold ack -> overrun, then ack clears both
    add(0, 1, 0, 0, 3, 1, 1, 0);
    add(0, 1, 1, 0, 3, 1, 1, 0);
    add(0, 1, 1, 0, 3, 1, 1, 1);
    add(0, 1, 0, 1, 3, 1, 0, 0);
    add(0, 1, 1, 0, 3, 1, 0, 0);
    add(0, 1, 1, 0, 3, 1, 1, 0);
    add(0, 1, 0, 0, 3, 1, 1, 0);
    add(0, 1, 1, 0, 3, 1, 1, 0);
    add(0, 1, 1, 0, 3, 1, 1, 1);
    add(0, 1, 0, 0, 3, 1, 1, 1);
    add(0, 1, 1, 0, 3, 1, 1, 1);
    add(0, 1, 1, 1, 3, 1, 1, 0);  // ack together with publish
    // N=5 source (high 4, low 1)
    add(0, 1, 1, 1, 3, 1, 0, 0);
    add(0, 1, 1, 0, 3, 1, 0, 0);
    add(0, 1, 0, 0, 3, 1, 0, 0);
    add(0, 1, 1, 0, 3, 1, 0, 0);
    add(0, 1, 1, 0, 5, 1, 1, 0);
    add(0, 1, 1, 1, 5, 1, 0, 0);
    add(0, 1, 1, 0, 5, 1, 0, 0);
    add(0, 1, 0, 0, 5, 1, 0, 0);
    add(0, 1, 1, 0, 5, 1, 0, 0);
    add(0, 1, 1, 0, 5, 1, 1, 0);
    // switch to high 6, low 1 -> 7/1, nothing in between
    add(0, 1, 1, 1, 5, 1, 0, 0);
    add(0, 1, 1, 0, 5, 1, 0, 0);
    add(0, 1, 1, 0, 5, 1, 0, 0);
    add(0, 1, 1, 0, 5, 1, 0, 0);
    add(0, 1, 0, 0, 5, 1, 0, 0);
    add(0, 1, 1, 0, 5, 1, 0, 0);
    add(0, 1, 1, 0, 7, 1, 1, 0);
    add(0, 1, 1, 0, 7, 1, 1, 0);
    // gate drop mid-period: result retained, no publish
    add(0, 0, 0, 0, 7, 1, 1, 0);
    add(0, 0, 1, 0, 7, 1, 1, 0);
    add(0, 1, 1, 0, 7, 1, 1, 0);  // rise seen in IDLE is ignored
    add(0, 1, 0, 1, 7, 1, 0, 0);
    add(0, 1, 1, 0, 7, 1, 0, 0);
    add(0, 1, 1, 0, 7, 1, 0, 0);  // first fresh rise arms
    add(0, 1, 0, 0, 7, 1, 0, 0);
    add(0, 1, 1, 0, 7, 1, 0, 0);
    add(0, 1, 1, 0, 3, 1, 1, 0);  // second rise publishes
    // build valid=1 overrun=1, then reset mid-measurement
    add(0, 1, 0, 0, 3, 1, 1, 0);
    add(0, 1, 1, 0, 3, 1, 1, 0);
    add(0, 1, 1, 0, 3, 1, 1, 1);
    add(0, 1, 0, 0, 3, 1, 1, 1);
    add(1, 1, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 3, 1, 1, 0);

    cyc();
    for (int i = 0; i < tv.size(); i++) begin
      rst = tv[i].rst;
      m_if.gate = tv[i].gate;
      m_if.sig  = tv[i].sig;
      m_if.ack  = tv[i].ack;
      cyc();
      chk($sformatf("row%0d", i),
          {m_if.period, m_if.low_time, m_if.valid, m_if.overrun, m_if.timeout},
          {tv[i].period, tv[i].low_time, tv[i].valid, tv[i].overrun, 1'b0});
    end
    m_if.gate = 1'b0; m_if.ack = 1'b0;

    // Timeout on the 4-bit instance: one rise, then sig held high.
    rst = 1'b1; cyc();
    rst = 1'b0;
    t_if.gate = 1'b1; t_if.sig = 1'b0; cyc();
    to_cnt = 0; to_at = 0; v_seen = 0;
    for (int k = 1; k <= 20; k++) begin
      t_if.sig = 1'b1;
      cyc();
      if (t_if.timeout === 1'b1) begin to_cnt++; to_at = k; end
      if (t_if.valid !== 1'b0) v_seen++;
    end
    chk("timeout_pulses", to_cnt, 1);
    chk("timeout_cycle", to_at, 17);
    chk("timeout_no_valid", v_seen, 0);

    // Back in ARM: full-scale period 15 must publish without timeout.
    to_cnt = 0;
    t_if.sig = 1'b0; cyc();
    for (int k = 0; k < 14; k++) begin
      t_if.sig = 1'b1; cyc();
      if (t_if.timeout === 1'b1) to_cnt++;
    end
    t_if.sig = 1'b0; cyc();
    if (t_if.timeout === 1'b1) to_cnt++;
    t_if.sig = 1'b1; cyc();
    if (t_if.timeout === 1'b1) to_cnt++;
    chk("max_pre_valid", t_if.valid, 1'b0);
    cyc();
    if (t_if.timeout === 1'b1) to_cnt++;
    chk("max_valid", t_if.valid, 1'b1);
    chk("max_period", t_if.period, 15);
    chk("max_low", t_if.low_time, 1);
    chk("max_no_timeout", to_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mode2_rate_meter.md
# mode2_rate_meter

Synchronous period/duty meter that receives a divide-by-n pulse train, such as the one produced by the team's Mode 2 rate generator, and recovers the divisor. It counts `clk` cycles between consecutive rising edges of `sig`, and counts the low samples within each period. Each result is presented on a valid/ack handshake, with overrun and timeout flags. It sits on the receiving side of a rate-generator output and checks or recovers the programmed divisor.

## Interface
- `CNT_W`, default 8: width of the period and low-time counters. Maximum measurable period is 2^CNT_W−1.
- `clk`  in  1  sole clock; all logic updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `gate`  in  1  measurement enable; low forces IDLE.
- `sig`  in  1  pulse train under measurement.
- `ack`  in  1  consumer accepts the current result.
- `period`  out  CNT_W  last measured period, in `clk` cycles.
- `low_time`  out  CNT_W  low samples of `sig` within that period.
- `valid`  out  1  result pending; held until `ack`.
- `overrun`  out  1  sticky; a result was overwritten before `ack`.
- `timeout`  out  1  one-cycle pulse; no edge arrived within the maximum period.

## Operation
- `sig` is registered into `s_q` each cycle; `s_qq` is the previous `s_q`. A rising edge is `rise = s_q & ~s_qq`.
- States:
  - **IDLE**: stays while `gate`=0; goes to ARM when `gate`=1.
  - **ARM**: waits for `rise`. On `rise`: `cnt`←1, `lcnt`←0, go to MEASURE.
  - **MEASURE**, on `rise`: publish `period`←`cnt` and `low_time`←`lcnt`; then `cnt`←1, `lcnt`←0; stay in MEASURE.
  - **MEASURE**, otherwise: `cnt`←`cnt`+1; `lcnt`←`lcnt`+(`s_q`==0).
  - **MEASURE**, when `cnt`==2^CNT_W−1 and no `rise`: pulse `timeout` for one cycle, go to ARM, publish nothing.
- `gate`=0 in any state: go to IDLE next cycle and clear `cnt`/`lcnt`. `period`, `low_time`, `valid` and `overrun` are retained. Re-arming requires two fresh edges before the next result.
- Publish:
  - `valid`←1.
  - If `valid` was already 1 and `ack`=0 in that cycle: overwrite the data and set `overrun`←1.
- `ack` while `valid`=1: `valid`←0 and `overrun`←0 next cycle.
- Publish and `ack` in the same cycle: `ack` consumes the old result. New data loads, `valid` stays 1, `overrun`←0.
- `ack` while `valid`=0 is ignored.
- Counters saturate logically via the timeout rule. `cnt` never wraps.
- Minimum measurable period is 2.

## Timing
- Reset values: state IDLE; `s_q`, `s_qq` and synchronizer flops 0; `cnt`, `lcnt`, `period`, `low_time` 0; `valid`, `overrun`, `timeout` 0.
- `rst` mid-measurement or with a result pending: everything returns to reset values next cycle. The result is discarded.
- Latency: `valid` rises 2 `clk` edges after the edge that first samples `sig`=1 (the closing edge of the period). With the synchronizer compiled in, it is 4.
- `period`/`low_time` change only on the same edge that sets `valid`.
- `timeout` rises on the edge where `cnt` would exceed 2^CNT_W−1 and lasts exactly one cycle.
- Expected values for a Mode 2 source with divisor N (high N−1, low 1): `period`=N, `low_time`=1.

## Configuration
- `MODE2_METER_SYNC_EN` defined:
  - A two-flop synchronizer is placed ahead of `s_q`, so `sig` may be asynchronous to `clk`.
  - Latency grows by 2 cycles; measured values are unchanged.
- Not defined: `sig` must be synchronous to `clk`, and only the single `s_q` register is used.

## Structure
- Package `mode2_pkg`: state enum typedef (IDLE, ARM, MEASURE) and the default `CNT_W` constant.
- Sub-module `mode2_edge_sync`:
  - Contains the optional synchronizer, `s_q`/`s_qq` and the `rise` output.
  - Outputs `s_q` and `rise` to the FSM/counter logic in `mode2_rate_meter`.

## Test plan
- Periodic source: `gate`=1; `sig` high 2, low 1, repeating (N=3). After the second rise, `period`=3, `low_time`=1, `valid`=1. Acking each result gives the same values repeatedly.
- Period change: N=5 source (high 4, low 1), then switched to high 6, low 1. Results are 5/1, then 7/1 once the new period completes, with no spurious value.
- Overrun and same-cycle publish: withhold `ack` across two N=3 results, giving `overrun`=1 and `period`=3 (latest). `ack` then clears `valid` and `overrun` next cycle. A further `ack` coinciding with a publish keeps `valid`=1 and `overrun`=0.
- Timeout: `CNT_W`=4; one rise, then `sig` held high. `timeout` pulses once, 15 cycles after the edge cycle; `valid` stays 0; the FSM returns to ARM.
- Gate drop: `gate`←0 mid-period. FSM enters IDLE with no publish. After `gate`←1, the first result appears only after two rises.
- Reset: assert `rst` in MEASURE with `valid`=1 and `overrun`=1. All outputs are 0 on the next edge; measurement restarts from IDLE.
